decoder_scan: RTL and testbench

Parametrised, registered IN_W-to-2^IN_W one-hot decoder with 74x138-style three-pin enable, plus an optional auto-scan mode. In auto-scan mode, an internal prescaler steps the selected output through indices 0..last_i. It is the next generation of the lab 3-8 decoder and drives LED banks and 7-segment digit selects directly from the board clock.

---
 rtl/decoder_scan.sv | 114 +++++++++++
 tb/tb_decoder_scan.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/decoder_scan.sv
// rtl/decoder_scan.sv - registered one-hot decoder with 74x138 enable and optional auto-scan (DECODER_SCAN_EN)
module decoder_scan #(
  parameter int IN_W  = 3,
  parameter int DIV_W = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic [2:0]             en_i,
  input  logic [IN_W-1:0]        data_i,
  input  logic                   mode_i,
  input  logic [DIV_W-1:0]       div_i,
  input  logic [IN_W-1:0]        last_i,
  output logic [(1<<IN_W)-1:0]   data_o,
  output logic [IN_W-1:0]        idx_o,
  output logic                   valid_o,
  output logic                   tick_o
);

  localparam int OUT_W = 1 << IN_W;

  // G1 high, G2A and G2B low
  logic en_ok;
  assign en_ok = (en_i == 3'b100);

  logic [OUT_W-1:0] data_q, data_d;
  logic [IN_W-1:0]  idx_q, idx_d;
  logic             valid_q, valid_d;
  logic             tick_q, tick_d;

`ifdef DECODER_SCAN_EN
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic [IN_W-1:0]  step_idx;

  // Next scan index: wraps to 0 at or beyond last_i, so lowering last_i restarts the sweep
  assign step_idx = (idx_q >= last_i) ? '0 : idx_q + IN_W'(1);
`else
  logic unused_scan;
  assign unused_scan = ^{mode_i, div_i, last_i};
`endif

  // Next-state selection: disable gating, then scan entry/run, otherwise plain decode
  always_comb begin
    data_d  = data_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    tick_d  = 1'b0;
`ifdef DECODER_SCAN_EN
    cnt_d   = cnt_q;
    mode_d  = mode_i;
`endif
    if (!en_ok) begin
      data_d  = '0;
      valid_d = 1'b0;
    end
`ifdef DECODER_SCAN_EN
    else if (mode_i && !mode_q) begin
      idx_d   = '0;
      cnt_d   = '0;
      data_d  = OUT_W'(1);
      valid_d = 1'b1;
    end else if (mode_i) begin
      if (cnt_q != div_i) begin
        cnt_d = cnt_q + DIV_W'(1);
      end else begin
        cnt_d  = '0;
        tick_d = 1'b1;
        idx_d  = step_idx;
      end
      data_d  = OUT_W'(1) << idx_d;
      valid_d = 1'b1;
    end
`endif
    else begin
      idx_d   = data_i;
      data_d  = OUT_W'(1) << data_i;
      valid_d = 1'b1;
    end
  end

  // Output registers, cleared asynchronously
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      data_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      data_q  <= data_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      tick_q  <= tick_d;
    end
  end

`ifdef DECODER_SCAN_EN
  // Prescaler and mode history; mode_q keeps tracking mode_i while disabled
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q  <= '0;
      mode_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
    end
  end
`endif

  assign data_o  = data_q;
  assign idx_o   = idx_q;
  assign valid_o = valid_q;
  assign tick_o  = tick_q;

endmodule

// File: tb/tb_decoder_scan.sv
// tb/tb_decoder_scan.sv - directed self-checking bench for decoder_scan
module tb_decoder_scan;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic [2:0]  en_i;
  logic [2:0]  data_i;
  logic        mode_i;
  logic [15:0] div_i;
  logic [2:0]  last_i;
  logic [7:0]  data_o;
  logic [2:0]  idx_o;
  logic        valid_o;
  logic        tick_o;

  int total = 0;
  int bad   = 0;

  decoder_scan #(.IN_W(3), .DIV_W(16)) dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .en_i    (en_i),
    .data_i  (data_i),
    .mode_i  (mode_i),
    .div_i   (div_i),
    .last_i  (last_i),
    .data_o  (data_o),
    .idx_o   (idx_o),
    .valid_o (valid_o),
    .tick_o  (tick_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [7:0] d, input logic [2:0] i,
                         input logic v, input logic t);
    chk({tag, "_data"},  32'(data_o),  32'(d));
    chk({tag, "_idx"},   32'(idx_o),   32'(i));
    chk({tag, "_valid"}, 32'(valid_o), 32'(v));
    chk({tag, "_tick"},  32'(tick_o),  32'(t));
  endtask

  initial begin
    rst_n_i = 1'b0;
    en_i    = 3'b100;
    data_i  = 3'd0;
    mode_i  = 1'b0;
    div_i   = 16'd0;
    last_i  = 3'd7;
    step();
    step();
    chk_out("reset", 8'h00, 3'd0, 1'b0, 1'b0);
    rst_n_i = 1'b1;

    // decode sweep
    for (int i = 0; i < 8; i++) begin
      data_i = 3'(i);
      step();
      chk_out("sweep", 8'(1 << i), 3'(i), 1'b1, 1'b0);
    end

    // enable off: outputs clear, idx holds at 7
    en_i   = 3'b101;
    data_i = 3'd0;
    step();
    chk_out("en_off", 8'h00, 3'd7, 1'b0, 1'b0);
    en_i = 3'b000;
    step();
    chk_out("en_off0", 8'h00, 3'd7, 1'b0, 1'b0);
    en_i = 3'b100;
    step();
    chk_out("en_on", 8'h01, 3'd0, 1'b1, 1'b0);

    // async reset mid-decode clears before any edge
    data_i = 3'd4;
    step();
    chk_out("pre_rst", 8'h10, 3'd4, 1'b1, 1'b0);
    #2 rst_n_i = 1'b0;
    #1;
    chk_out("async_rst", 8'h00, 3'd0, 1'b0, 1'b0);
    step();
    rst_n_i = 1'b1;

`ifdef DECODER_SCAN_EN
    // scan: div 2, last 5
    data_i = 3'd0;
    mode_i = 1'b0;
    div_i  = 16'd2;
    last_i = 3'd5;
    step();
    mode_i = 1'b1;
    for (int s = 0; s <= 18; s++) begin
      int e;
      step();
      e = (s / 3) % 6;
      chk_out("scan", 8'(1 << e), 3'(e), 1'b1, (s > 0) && (s % 3 == 0));
    end

    // freeze at idx 3 with cnt 1 (state s = 10 after fresh entry)
    mode_i = 1'b0;
    step();
    mode_i = 1'b1;
    for (int s = 0; s <= 10; s++) step();
    chk_out("frz_pre", 8'h08, 3'd3, 1'b1, 1'b0);
    en_i = 3'b000;
    for (int k = 0; k < 10; k++) begin
      step();
      chk_out("frz", 8'h00, 3'd3, 1'b0, 1'b0);
    end
    en_i = 3'b100;
    step();
    chk_out("frz_re1", 8'h08, 3'd3, 1'b1, 1'b0);
    step();
    chk_out("frz_re2", 8'h10, 3'd4, 1'b1, 1'b1);

    // wrap on last_i change, div 0
    mode_i = 1'b0;
    div_i  = 16'd0;
    last_i = 3'd7;
    step();
    mode_i = 1'b1;
    for (int s = 0; s <= 5; s++) step();
    chk_out("wrap_pre", 8'h20, 3'd5, 1'b1, 1'b1);
    last_i = 3'd2;
    step();
    chk_out("wrap0", 8'h01, 3'd0, 1'b1, 1'b1);
    step();
    step();
    chk_out("wrap2", 8'h04, 3'd2, 1'b1, 1'b1);
    step();
    chk_out("wrap3", 8'h01, 3'd0, 1'b1, 1'b1);
    last_i = 3'd0;
    step();
    chk_out("last0a", 8'h01, 3'd0, 1'b1, 1'b1);
    step();
    chk_out("last0b", 8'h01, 3'd0, 1'b1, 1'b1);

    // scan exit performs a decode load
    mode_i = 1'b0;
    data_i = 3'd6;
    step();
    chk_out("exit", 8'h40, 3'd6, 1'b1, 1'b0);

    // reset mid-scan at idx 4, div 1
    div_i  = 16'd1;
    last_i = 3'd7;
    mode_i = 1'b1;
    for (int s = 0; s <= 8; s++) step();
    chk_out("rscan_pre", 8'h10, 3'd4, 1'b1, 1'b1);
    #2 rst_n_i = 1'b0;
    #1;
    chk_out("rscan", 8'h00, 3'd0, 1'b0, 1'b0);
    step();
    rst_n_i = 1'b1;
    step();
    chk_out("rscan_entry", 8'h01, 3'd0, 1'b1, 1'b0);
    step();
    chk_out("rscan_s1", 8'h01, 3'd0, 1'b1, 1'b0);
    step();
    chk_out("rscan_s2", 8'h02, 3'd1, 1'b1, 1'b1);
`else
    // scan disabled: mode_i = 1 is plain decode, tick stays 0
    mode_i = 1'b1;
    div_i  = 16'd0;
    last_i = 3'd2;
    for (int k = 0; k < 4; k++) begin
      data_i = 3'(5 - k);
      step();
      chk_out("noscan", 8'(1 << (5 - k)), 3'(5 - k), 1'b1, 1'b0);
    end
    en_i = 3'b110;
    step();
    chk_out("noscan_off", 8'h00, 3'd2, 1'b0, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
